imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate width; legal values 32, 64.
REQ-002 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept an instruction.
REQ-007 in_instr  input  32  instruction word.
REQ-008 out_valid  output  1  decoded result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_imm  output  XLEN  extended immediate.
REQ-011 out_fmt  output  3  immediate format code.
REQ-012 out_illegal  output  1  opcode not recognised.
REQ-013 illegal_cnt  output  CNT_W  saturating count of illegal instructions accepted.

Function
REQ-014 Format codes SHALL be: I=000, S=001, B=010, U=011, J=100, Z=101, NONE=110, ILL=111.
REQ-015 Format SHALL be decoded from opcode in_instr[6:0]:
- 0000011, 0010011, 1100111, 0001111 -> I
- 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J
- 1110011 -> Z if instr[14]=1, else I
- 0110011 -> NONE
- XLEN=64 only: 0011011 -> I, 0111011 -> NONE
- all others -> ILL, out_illegal=1.
REQ-016 I/S/B/U/J immediates SHALL use standard RISC-V bit placement, sign-extended from instr[31] to XLEN; U = {instr[31:12],12'b0} sign-extended; B and J have bit 0 = 0.
REQ-017 Z SHALL be instr[19:15] zero-extended to XLEN.
REQ-018 NONE and ILL SHALL yield out_imm = 0.
REQ-019 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-020 Results SHALL be held in a 2-entry FIFO; the decoded result is written on the input transfer and out_valid rises the following cycle (latency 1).
REQ-021 in_ready SHALL equal (occupancy < 2), registered-state-only, with no combinational path from out_ready.
REQ-022 out_valid SHALL equal (occupancy > 0); out_imm/out_fmt/out_illegal SHALL be the head entry and stay stable while out_valid && !out_ready.
REQ-023 Simultaneous input and output transfer SHALL leave occupancy unchanged, preserving order.
REQ-024 Read and write pointers SHALL be 1 bit each and wrap 1 -> 0.
REQ-025 illegal_cnt SHALL increment on each input transfer decoded as ILL and saturate at all-ones.

Reset
REQ-026 On reset_n low, asynchronously: occupancy=0, pointers=0, illegal_cnt=0, out_valid=0, in_ready=0.
REQ-027 in_ready SHALL rise in the first cycle after reset_n deasserts.
REQ-028 Reset mid-operation SHALL discard all buffered entries; no stale output SHALL appear after release.
REQ-029 FIFO data storage need not be reset; outputs SHALL be qualified only by out_valid.

Structure
REQ-030 Shared package imm_pkg SHALL hold the format enum (imm_fmt_t), opcode localparams, and a decode function returning {fmt, illegal}.
REQ-031 A natural sub-module is imm_fifo2 (2-entry parametrised-width FIFO); extension logic stays in imm_decode_stage.
REQ-032 The module SHALL elaborate-time error on XLEN not in {32, 64}.

Verification
REQ-033 XLEN=32, in_instr=0xFFF00093 (addi -1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=000.
REQ-034 XLEN=32, 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=010; 0x000FD073 (csrrwi uimm 31) -> out_imm=0x0000001F, fmt=101.
REQ-035 XLEN=64, 0x80000037 (lui) -> out_imm=0xFFFFFFFF80000000, fmt=011; 0x0000001B -> fmt=000, illegal=0; same word at XLEN=32 -> fmt=111, illegal=1, imm=0.
REQ-036 out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 from the cycle after the second; then out_ready=1 -> outputs in order, third accepted once in_ready=1.
REQ-037 CNT_W=2, five 0x0000007F transfers -> illegal_cnt 1,2,3,3,3.
REQ-038 Two entries buffered, reset_n pulsed low mid-cycle -> out_valid=0 and illegal_cnt=0 immediately; after release no entry emitted until a new input.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg -- shared definitions for the immediate decode stage.
//   imm_fmt_t  : 3-bit immediate format code carried with every result
//   OP_*       : major opcode values (instr[6:0]) recognised by the decoder
//   dec_t      : decoder result {fmt, illegal}
//   imm_decode : opcode -> {fmt, illegal}; rv64 enables the *W opcodes
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'b000,
    FMT_S    = 3'b001,
    FMT_B    = 3'b010,
    FMT_U    = 3'b011,
    FMT_J    = 3'b100,
    FMT_Z    = 3'b101,
    FMT_NONE = 3'b110,
    FMT_ILL  = 3'b111
  } imm_fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef struct packed {
    imm_fmt_t fmt;
    logic     illegal;
  } dec_t;

  // f3_msb is instr[14]: on SYSTEM it separates the CSR*I forms (uimm in
  // rs1 field) from everything else, which carries an I-type immediate.
  function automatic dec_t imm_decode(input logic [6:0] op,
                                      input logic       f3_msb,
                                      input logic       rv64);
    dec_t d;
    d.fmt     = FMT_ILL;
    d.illegal = 1'b0;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: d.fmt = FMT_I;
      OP_STORE:          d.fmt = FMT_S;
      OP_BRANCH:         d.fmt = FMT_B;
      OP_LUI, OP_AUIPC:  d.fmt = FMT_U;
      OP_JAL:            d.fmt = FMT_J;
      OP_SYSTEM:         d.fmt = f3_msb ? FMT_Z : FMT_I;
      OP_REG:            d.fmt = FMT_NONE;
      OP_IMM32:          d.fmt = rv64 ? FMT_I    : FMT_ILL;
      OP_REG32:          d.fmt = rv64 ? FMT_NONE : FMT_ILL;
      default:           d.fmt = FMT_ILL;
    endcase
    d.illegal = (d.fmt == FMT_ILL);
    return d;
  endfunction

endpackage

// File: rtl/imm_fifo2.sv
// imm_fifo2 -- 2-entry FIFO, 1-bit pointers.
//   clk, reset_n : clock, async active-low reset
//   push, pop    : qualified transfers (caller gates with wr_ready/rd_valid)
//   wdata        : entry written on push
//   wr_ready     : space available; from registered state only, low in reset
//                  and until the first clock after release
//   rd_valid     : head entry valid
//   rdata        : head entry (storage is not reset; qualify with rd_valid)
module imm_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         wr_ready,
  output logic         rd_valid,
  output logic [W-1:0] rdata
);

  logic [1:0][W-1:0] mem;
  logic              wptr, rptr;
  logic [1:0]        count;
  logic              armed;   // set one clock after reset release

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign wr_ready = armed & ~count[1];
  assign rd_valid = (count != 2'd0);
  assign rdata    = mem[rptr];

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage -- decodes the immediate of a RISC-V instruction word and
// buffers {imm, fmt, illegal} in a 2-entry FIFO (latency 1).
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake; in_ready is registered-only
//   in_instr              : 32-bit instruction word
//   out_valid/out_ready   : downstream handshake
//   out_imm/fmt/illegal   : head-of-FIFO result, stable while stalled
//   illegal_cnt           : saturating count of accepted illegal opcodes
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_t        fmt;
    logic            illegal;
  } res_t;

  localparam logic RV64 = (XLEN == 64);

  dec_t        dec;
  logic [31:0] imm32;
  res_t        wr_res, rd_res;
  logic        in_fire, out_fire;

  assign dec = imm_decode(in_instr[6:0], in_instr[14], RV64);

  // Every format's 32-bit image has instr[31] in bit 31 except Z, whose
  // bit 31 is 0, so one sign-extension to XLEN covers all cases.
  always_comb begin
    imm32 = '0;
    case (dec.fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z: imm32 = {27'b0, in_instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign wr_res.imm     = XLEN'($signed(imm32));
  assign wr_res.fmt     = dec.fmt;
  assign wr_res.illegal = dec.illegal;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  imm_fifo2 #(.W($bits(res_t))) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (in_fire),
    .pop      (out_fire),
    .wdata    (wr_res),
    .wr_ready (in_ready),
    .rd_valid (out_valid),
    .rdata    (rd_res)
  );

  assign out_imm     = rd_res.imm;
  assign out_fmt     = rd_res.fmt;
  assign out_illegal = rd_res.illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_cnt <= '0;
    end else if (in_fire && dec.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: expected results are queued at each input transfer and
// a monitor per instance pops and compares at each output transfer.
// Instance A: XLEN=32, CNT_W=2.  Instance B: XLEN=64, CNT_W=16.
module tb_imm_decode_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance A
  logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ill;
  logic [31:0] a_in_instr, a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [1:0]  a_cnt;
  exp_t        a_exp;
  exp_t        a_q[$];

  // instance B
  logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ill;
  logic [31:0] b_in_instr;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [15:0] b_cnt;
  exp_t        b_exp;
  exp_t        b_q[$];

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut_a (
    .clk(clk), .reset_n(a_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_ill),
    .illegal_cnt(a_cnt)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_ill),
    .illegal_cnt(b_cnt)
  );

  // input side: record expectation at each accepted transfer
  always @(negedge clk) if (a_rst_n && a_in_valid && a_in_ready) a_q.push_back(a_exp);
  always @(negedge clk) if (b_rst_n && b_in_valid && b_in_ready) b_q.push_back(b_exp);

  // output monitors
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && a_out_ready) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_out: got imm=%h fmt=%b ill=%b, required no output",
                 a_out_imm, a_out_fmt, a_out_ill);
      end else begin
        e = a_q.pop_front();
        if (a_out_imm !== e.imm[31:0] || a_out_fmt !== e.fmt || a_out_ill !== e.ill) begin
          errors++;
          $display("FAIL a_out: got imm=%h fmt=%b ill=%b, required imm=%h fmt=%b ill=%b",
                   a_out_imm, a_out_fmt, a_out_ill, e.imm[31:0], e.fmt, e.ill);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_out_valid && b_out_ready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_out: got imm=%h fmt=%b ill=%b, required no output",
                 b_out_imm, b_out_fmt, b_out_ill);
      end else begin
        e = b_q.pop_front();
        if (b_out_imm !== e.imm || b_out_fmt !== e.fmt || b_out_ill !== e.ill) begin
          errors++;
          $display("FAIL b_out: got imm=%h fmt=%b ill=%b, required imm=%h fmt=%b ill=%b",
                   b_out_imm, b_out_fmt, b_out_ill, e.imm, e.fmt, e.ill);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one instruction until accepted; returns 1ns after the accepting edge.
  task automatic send_a(input logic [31:0] instr, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
    bit ok;
    ok = 1'b0;
    a_in_instr = instr;
    a_exp      = '{imm, fmt, ill};
    a_in_valid = 1'b1;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk); ok = a_in_ready;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL a_send_timeout: instr %h never accepted", instr);
    end
  endtask

  task automatic send_b(input logic [31:0] instr, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
    bit ok;
    ok = 1'b0;
    b_in_instr = instr;
    b_exp      = '{imm, fmt, ill};
    b_in_valid = 1'b1;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk); ok = b_in_ready;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL b_send_timeout: instr %h never accepted", instr);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (a_q.size() != 0 || b_q.size() != 0); n++) @(posedge clk);
    #1;
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d, required 0", a_q.size(), b_q.size());
    end
  endtask

  initial begin
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_out_ready = 1'b1;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_out_ready = 1'b1;
    a_exp = '{64'd0, 3'd0, 1'b0};
    b_exp = '{64'd0, 3'd0, 1'b0};

    // reset state
    #3;
    chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("a_rst_in_ready",  64'(a_in_ready),  64'd0);
    chk("a_rst_cnt",       64'(a_cnt),       64'd0);
    chk("b_rst_in_ready",  64'(b_in_ready),  64'd0);
    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("a_in_ready_after_rst", 64'(a_in_ready), 64'd1);
    chk("b_in_ready_after_rst", 64'(b_in_ready), 64'd1);

    // addi -1: result visible the cycle after acceptance
    send_a(32'hFFF00093, 64'hFFFFFFFF, 3'b000, 1'b0);
    chk("a_lat1_valid", 64'(a_out_valid), 64'd1);
    chk("a_lat1_imm",   64'(a_out_imm),   64'hFFFFFFFF);
    chk("a_lat1_fmt",   64'(a_out_fmt),   64'd0);

    send_a(32'hFE000EE3, 64'hFFFFFFFC, 3'b010, 1'b0);  // beq -4
    send_a(32'h000FD073, 64'h0000001F, 3'b101, 1'b0);  // csrrwi uimm 31
    send_a(32'h0000001B, 64'h0,        3'b111, 1'b1);  // addiw: illegal on RV32
    send_a(32'hFE112E23, 64'hFFFFFFFC, 3'b001, 1'b0);  // sw -4
    send_a(32'h12345037, 64'h12345000, 3'b011, 1'b0);  // lui
    send_a(32'h0080006F, 64'h00000008, 3'b100, 1'b0);  // jal +8
    send_a(32'hFFDFF06F, 64'hFFFFFFFC, 3'b100, 1'b0);  // jal -4
    send_a(32'h00B50533, 64'h0,        3'b110, 1'b0);  // add
    send_a(32'h300022F3, 64'h00000300, 3'b000, 1'b0);  // csrrs: I form
    drain();

    // backpressure: two accepted, third waits
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_instr  = 32'h00100093; a_exp = '{64'd1, 3'b000, 1'b0};
    @(negedge clk); chk("a_bp_rdy1", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_instr  = 32'h00200093; a_exp = '{64'd2, 3'b000, 1'b0};
    @(negedge clk); chk("a_bp_rdy2", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1;
    a_in_instr  = 32'h00300093; a_exp = '{64'd3, 3'b000, 1'b0};
    @(negedge clk);
    chk("a_bp_full",      64'(a_in_ready),  64'd0);
    chk("a_bp_valid",     64'(a_out_valid), 64'd1);
    chk("a_bp_head",      64'(a_out_imm),   64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("a_bp_full_hold", 64'(a_in_ready),  64'd0);
    chk("a_bp_head_hold", 64'(a_out_imm),   64'd1);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    send_a(32'h00300093, 64'd3, 3'b000, 1'b0);
    drain();

    // saturating counter, CNT_W=2
    a_rst_n = 1'b0; #1; a_q.delete();
    @(posedge clk); #1; a_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      send_a(32'h0000007F, 64'h0, 3'b111, 1'b1);
      chk($sformatf("a_cnt_%0d", k), 64'(a_cnt), 64'(exp_cnt[k]));
    end
    drain();

    // reset with two entries buffered
    a_out_ready = 1'b0;
    send_a(32'h0000007F, 64'h0, 3'b111, 1'b1);
    send_a(32'h00500093, 64'd5, 3'b000, 1'b0);
    chk("a_pre_rst_full", 64'(a_in_ready), 64'd0);
    #2 a_rst_n = 1'b0;
    #1;
    chk("a_mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("a_mid_rst_cnt",   64'(a_cnt),       64'd0);
    chk("a_mid_rst_rdy",   64'(a_in_ready),  64'd0);
    a_q.delete();
    @(posedge clk); #1;
    a_rst_n = 1'b1; a_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk($sformatf("a_no_stale_%0d", k), 64'(a_out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send_a(32'hFFF00093, 64'hFFFFFFFF, 3'b000, 1'b0);
    drain();

    // XLEN=64
    send_b(32'h80000037, 64'hFFFFFFFF80000000, 3'b011, 1'b0);  // lui
    send_b(32'h0000001B, 64'h0,                3'b000, 1'b0);  // addiw
    send_b(32'h0000003B, 64'h0,                3'b110, 1'b0);  // addw
    send_b(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0);
    send_b(32'h000FD073, 64'h000000000000001F, 3'b101, 1'b0);
    send_b(32'h0000007F, 64'h0,                3'b111, 1'b1);
    drain();
    chk("b_cnt", 64'(b_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
